// File: rtl/commit_trace_checker.sv
// commit_trace_checker
//   In-order checker for the architectural commit stream. A golden trace is
//   preloaded into an internal table; once started, every cycle's writeback,
//   memory-stage and halt events are compared against the next golden
//   entries. Reports pass/fail, the first divergence, and instruction and
//   cycle counts.
//
//   Golden entry layout (38 bits):
//     [37:36] type (0 REG, 1 LOAD, 2 STORE, 3 HALT)
//     [35:32] reg   [31:16] addr   [15:0] value
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   gold_we/waddr/wdata   golden table write port (ignored while running)
//   gold_count            number of valid golden entries, sampled on start
//   start                 one-cycle pulse: clear and begin checking
//   reg_write/wr_reg/wr_data                   WB register write
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  MEM-stage access
//   halt                  halt reached MEM/WB
//   done/pass/fail        terminal status
//   fail_code             0 none, 1 mismatch, 2 overrun, 3 early halt,
//                         4 timeout, 5 protocol
//   fail_idx, exp_entry, act_entry  first failure details
//   ptr                   next golden index to match
//   inst_count, cycle_count         committed instructions / run cycles

module commit_trace_checker #(
  parameter int IDX_W       = 10,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gold_we,
  input  logic [IDX_W-1:0] gold_waddr,
  input  logic [37:0]      gold_wdata,
  input  logic [IDX_W:0]   gold_count,
  input  logic             start,
  input  logic             reg_write,
  input  logic [3:0]       wr_reg,
  input  logic [15:0]      wr_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             halt,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [IDX_W:0]   fail_idx,
  output logic [37:0]      exp_entry,
  output logic [37:0]      act_entry,
  output logic [IDX_W:0]   ptr,
  output logic [31:0]      inst_count,
  output logic [31:0]      cycle_count
);

  localparam int CW    = IDX_W + 1;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_MISMATCH = 3'd1;
  localparam logic [2:0] FC_OVERRUN  = 3'd2;
  localparam logic [2:0] FC_EARLY    = 3'd3;
  localparam logic [2:0] FC_TIMEOUT  = 3'd4;
  localparam logic [2:0] FC_PROTOCOL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Field comparison depends on the type of the live event: registers
  // compare reg+value, memory ops compare addr+value, halt compares type only.
  function automatic logic entry_match(input logic [37:0] e, input logic [37:0] a);
    logic m;
    case (a[37:36])
      2'd0:    m = (e[37:36] == a[37:36]) && (e[35:32] == a[35:32]) && (e[15:0] == a[15:0]);
      2'd1,
      2'd2:    m = (e[37:36] == a[37:36]) && (e[31:16] == a[31:16]) && (e[15:0] == a[15:0]);
      2'd3:    m = (e[37:36] == a[37:36]);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic [37:0]   r_table [0:DEPTH-1];
  state_t        r_state;
  logic [CW-1:0] r_gold_count;
  logic [CW-1:0] r_ptr;
  logic [31:0]   r_inst_count;
  logic [31:0]   r_cycle_count;
  logic          r_done;
  logic          r_pass;
  logic          r_fail;
  logic [2:0]    r_fail_code;
  logic [CW-1:0] r_fail_idx;
  logic [37:0]   r_exp_entry;
  logic [37:0]   r_act_entry;

  logic [37:0]          w_reg_ev;
  logic [37:0]          w_mem_ev;
  logic [37:0]          w_halt_ev;
  logic                 w_mem_v;
  logic [1:0]           w_n;
  logic [2:0][37:0]     w_ev;
  logic [2:0]           w_ev_v;
  logic [2:0][CW-1:0]   w_rd_idx;
  logic [2:0][37:0]     w_exp;
  logic [2:0]           w_ovr;
  logic [2:0]           w_mis;
  logic                 w_protocol;
  logic                 w_adv;
  logic                 w_timeout;
  logic [CW-1:0]        w_ptr_next;
  logic [1:0]           w_ovr_k;
  logic [1:0]           w_mis_k;
  logic                 w_fail_now;
  logic                 w_pass_now;
  logic [2:0]           w_fail_code;
  logic [CW-1:0]        w_fail_idx;
  logic [37:0]          w_fail_exp;
  logic [37:0]          w_fail_act;

  // Golden table write port; frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (gold_we && (r_state != ST_RUN)) begin
      r_table[gold_waddr] <= gold_wdata;
    end
  end

  assign w_reg_ev  = {2'd0, wr_reg, 16'd0, wr_data};
  assign w_mem_ev  = mem_read ? {2'd1, 4'd0, mem_addr, mem_rdata}
                              : {2'd2, 4'd0, mem_addr, mem_wdata};
  assign w_halt_ev = {2'd3, 36'd0};
  assign w_mem_v   = mem_read | mem_write;
  assign w_n       = {1'b0, reg_write} + {1'b0, w_mem_v} + {1'b0, halt};

  // Pack the cycle's events densely in REG, MEM, HALT order.
  assign w_ev[0] = reg_write ? w_reg_ev :
                   (w_mem_v ? w_mem_ev : (halt ? w_halt_ev : 38'd0));
  assign w_ev[1] = reg_write ? (w_mem_v ? w_mem_ev : (halt ? w_halt_ev : 38'd0)) :
                   ((w_mem_v & halt) ? w_halt_ev : 38'd0);
  assign w_ev[2] = (reg_write & w_mem_v & halt) ? w_halt_ev : 38'd0;

  assign w_ev_v[0] = (w_n != 2'd0);
  assign w_ev_v[1] = (w_n > 2'd1);
  assign w_ev_v[2] = (w_n == 2'd3);

  // Three read ports at ptr, ptr+1, ptr+2; indices are one bit wider than
  // the table so out-of-range slots are detected rather than wrapped.
  assign w_rd_idx[0] = r_ptr;
  assign w_rd_idx[1] = r_ptr + CW'(2'd1);
  assign w_rd_idx[2] = r_ptr + CW'(2'd2);
  assign w_exp[0]    = r_table[w_rd_idx[0][IDX_W-1:0]];
  assign w_exp[1]    = r_table[w_rd_idx[1][IDX_W-1:0]];
  assign w_exp[2]    = r_table[w_rd_idx[2][IDX_W-1:0]];

  assign w_ovr[0] = w_ev_v[0] & (w_rd_idx[0] >= r_gold_count);
  assign w_ovr[1] = w_ev_v[1] & (w_rd_idx[1] >= r_gold_count);
  assign w_ovr[2] = w_ev_v[2] & (w_rd_idx[2] >= r_gold_count);
  assign w_mis[0] = w_ev_v[0] & ~entry_match(w_exp[0], w_ev[0]);
  assign w_mis[1] = w_ev_v[1] & ~entry_match(w_exp[1], w_ev[1]);
  assign w_mis[2] = w_ev_v[2] & ~entry_match(w_exp[2], w_ev[2]);

  assign w_protocol = mem_read & mem_write;
  assign w_adv      = ~w_protocol & ~(|w_ovr) & ~(|w_mis);
  assign w_ptr_next = r_ptr + {{(CW-2){1'b0}}, w_n};
  assign w_timeout  = ((r_cycle_count + 32'd1) == 32'(CYCLE_LIMIT));
  assign w_ovr_k    = w_ovr[0] ? 2'd0 : (w_ovr[1] ? 2'd1 : 2'd2);
  assign w_mis_k    = w_mis[0] ? 2'd0 : (w_mis[1] ? 2'd1 : 2'd2);

  // Terminal decision for the current run cycle, highest priority first.
  always_comb begin
    w_fail_now  = 1'b0;
    w_pass_now  = 1'b0;
    w_fail_code = FC_NONE;
    w_fail_idx  = '0;
    w_fail_exp  = 38'd0;
    w_fail_act  = 38'd0;
    if (w_protocol) begin
      w_fail_now  = 1'b1;
      w_fail_code = FC_PROTOCOL;
      w_fail_idx  = r_ptr;
    end else if (|w_ovr) begin
      w_fail_now  = 1'b1;
      w_fail_code = FC_OVERRUN;
      w_fail_idx  = w_rd_idx[w_ovr_k];
      w_fail_act  = w_ev[w_ovr_k];
    end else if (|w_mis) begin
      w_fail_now  = 1'b1;
      w_fail_code = FC_MISMATCH;
      w_fail_idx  = w_rd_idx[w_mis_k];
      w_fail_exp  = w_exp[w_mis_k];
      w_fail_act  = w_ev[w_mis_k];
    end else if (halt) begin
      if (w_ptr_next == r_gold_count) begin
        w_pass_now = 1'b1;
      end else begin
        w_fail_now  = 1'b1;
        w_fail_code = FC_EARLY;
        w_fail_idx  = w_ptr_next;
        w_fail_act  = w_halt_ev;
      end
    end else if (w_timeout) begin
      w_fail_now  = 1'b1;
      w_fail_code = FC_TIMEOUT;
      w_fail_idx  = w_ptr_next;
    end else begin
      w_fail_now = 1'b0;
    end
  end

  // Control FSM with registered status, pointer, counters and fail capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_gold_count  <= '0;
      r_ptr         <= '0;
      r_inst_count  <= 32'd0;
      r_cycle_count <= 32'd0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_code   <= FC_NONE;
      r_fail_idx    <= '0;
      r_exp_entry   <= 38'd0;
      r_act_entry   <= 38'd0;
    end else if (start) begin
      // Commit inputs in the start cycle are deliberately ignored.
      r_state       <= ST_RUN;
      r_gold_count  <= gold_count;
      r_ptr         <= '0;
      r_inst_count  <= 32'd0;
      r_cycle_count <= 32'd0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_code   <= FC_NONE;
      r_fail_idx    <= '0;
      r_exp_entry   <= 38'd0;
      r_act_entry   <= 38'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_cycle_count != 32'hFFFF_FFFF) begin
            r_cycle_count <= r_cycle_count + 32'd1;
          end
          if ((reg_write | mem_write | halt) && (r_inst_count != 32'hFFFF_FFFF)) begin
            r_inst_count <= r_inst_count + 32'd1;
          end
          if (w_adv) begin
            r_ptr <= w_ptr_next;
          end
          if (w_fail_now) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_code <= w_fail_code;
            r_fail_idx  <= w_fail_idx;
            r_exp_entry <= w_fail_exp;
            r_act_entry <= w_fail_act;
          end else if (w_pass_now) begin
            r_state <= ST_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_code   = r_fail_code;
  assign fail_idx    = r_fail_idx;
  assign exp_entry   = r_exp_entry;
  assign act_entry   = r_act_entry;
  assign ptr         = r_ptr;
  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_commit_trace_checker.sv
module tb_commit_trace_checker;

  localparam int IDX_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             gold_we;
  logic [IDX_W-1:0] gold_waddr;
  logic [37:0]      gold_wdata;
  logic [IDX_W:0]   gold_count;
  logic             start;
  logic             reg_write;
  logic [3:0]       wr_reg;
  logic [15:0]      wr_data;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             halt;
  logic             done;
  logic             pass;
  logic             fail;
  logic [2:0]       fail_code;
  logic [IDX_W:0]   fail_idx;
  logic [37:0]      exp_entry;
  logic [37:0]      act_entry;
  logic [IDX_W:0]   ptr;
  logic [31:0]      inst_count;
  logic [31:0]      cycle_count;

  commit_trace_checker #(.IDX_W(IDX_W), .CYCLE_LIMIT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .gold_we(gold_we), .gold_waddr(gold_waddr), .gold_wdata(gold_wdata),
    .gold_count(gold_count), .start(start),
    .reg_write(reg_write), .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .fail_idx(fail_idx), .exp_entry(exp_entry), .act_entry(act_entry),
    .ptr(ptr), .inst_count(inst_count), .cycle_count(cycle_count)
  );

  typedef struct {
    logic        pass;
    logic [2:0]  code;
    logic [10:0] idx;
    logic [10:0] ptr;
    logic [31:0] inst;
    logic [31:0] cyc;
    logic [37:0] exp_e;
    logic [37:0] act_e;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   ok;

  function automatic logic [37:0] mk(input logic [1:0] t, input logic [3:0] r,
                                     input logic [15:0] a, input logic [15:0] v);
    return {t, r, a, v};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    reg_write = 1'b0; wr_reg = 4'd0; wr_data = 16'd0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 16'd0;
    mem_wdata = 16'd0; mem_rdata = 16'd0; halt = 1'b0;
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [37:0] d);
    gold_we = 1'b1; gold_waddr = a; gold_wdata = d;
    cyc();
    gold_we = 1'b0;
  endtask

  task automatic do_start(input logic [IDX_W:0] cnt);
    gold_count = cnt; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in(); start = 1'b0; gold_we = 1'b0;
    gold_waddr = '0; gold_wdata = 38'd0; gold_count = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({done, pass, fail, fail_code} !== 6'd0) $display("FAIL reset_status got %b want 0", {done, pass, fail, fail_code});
    else n_pass++;
    n_checks++;
    if ({ptr, inst_count, cycle_count} !== 75'd0) $display("FAIL reset_counters ptr=%0d inst=%0d cyc=%0d want 0", ptr, inst_count, cycle_count);
    else n_pass++;
    n_checks++;
    if ({fail_idx, exp_entry, act_entry} !== 87'd0) $display("FAIL reset_fields idx=%0d exp=%h act=%h want 0", fail_idx, exp_entry, act_entry);
    else n_pass++;
  endtask

  task automatic test_pass_basic(input bit do_load);
    if (do_load) begin
      load(10'd0, mk(2'd0, 4'd1, 16'h0000, 16'h0005));
      load(10'd1, mk(2'd2, 4'd0, 16'h0010, 16'h0005));
      load(10'd2, mk(2'd3, 4'd0, 16'h0000, 16'h0000));
    end
    do_start(11'd3);
    cyc();
    reg_write = 1'b1; wr_reg = 4'd1; wr_data = 16'h0005;
    cyc(); idle_in();
    cyc();
    mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h0005; halt = 1'b1;
    e = '{pass:1'b1, code:3'd0, idx:11'd0, ptr:11'd3, inst:32'd2, cyc:32'd4, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL pass_basic_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({done, pass, fail, fail_code} !== {1'b1, e.pass, ~e.pass, e.code})
      $display("FAIL pass_basic_status got %b want %b", {done, pass, fail, fail_code}, {1'b1, e.pass, ~e.pass, e.code});
    else n_pass++;
    n_checks++;
    if ({ptr, inst_count, cycle_count} !== {e.ptr, e.inst, e.cyc})
      $display("FAIL pass_basic_counts got ptr=%0d inst=%0d cyc=%0d want %0d/%0d/%0d", ptr, inst_count, cycle_count, e.ptr, e.inst, e.cyc);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    do_start(11'd3);
    reg_write = 1'b1; wr_reg = 4'd1; wr_data = 16'h0006;
    e = '{pass:1'b0, code:3'd1, idx:11'd0, ptr:11'd0, inst:32'd1, cyc:32'd1,
          exp_e:mk(2'd0, 4'd1, 16'h0000, 16'h0005), act_e:mk(2'd0, 4'd1, 16'h0000, 16'h0006)};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL mismatch_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({done, pass, fail, fail_code, fail_idx} !== {1'b1, e.pass, ~e.pass, e.code, e.idx})
      $display("FAIL mismatch_status got code=%0d idx=%0d fail=%b want code=%0d idx=%0d", fail_code, fail_idx, fail, e.code, e.idx);
    else n_pass++;
    n_checks++;
    if ({exp_entry, act_entry} !== {e.exp_e, e.act_e})
      $display("FAIL mismatch_entries got exp=%h act=%h want exp=%h act=%h", exp_entry, act_entry, e.exp_e, e.act_e);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      reg_write = 1'($urandom); wr_reg = 4'($urandom); wr_data = 16'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom); halt = 1'($urandom);
      cyc();
    end
    idle_in();
    n_checks++;
    if ({done, pass, fail, fail_code, fail_idx, exp_entry, act_entry, ptr, inst_count, cycle_count} !==
        {1'b1, 1'b0, 1'b1, e.code, e.idx, e.exp_e, e.act_e, e.ptr, e.inst, e.cyc})
      $display("FAIL mismatch_hold got code=%0d idx=%0d ptr=%0d inst=%0d cyc=%0d want %0d/%0d/%0d/%0d/%0d",
               fail_code, fail_idx, ptr, inst_count, cycle_count, e.code, e.idx, e.ptr, e.inst, e.cyc);
    else n_pass++;
  endtask

  task automatic test_dual_issue();
    load(10'd0, mk(2'd0, 4'd2, 16'h0000, 16'h1234));
    load(10'd1, mk(2'd1, 4'd0, 16'h0020, 16'hBEEF));
    load(10'd2, mk(2'd3, 4'd0, 16'h0000, 16'h0000));
    do_start(11'd3);
    reg_write = 1'b1; wr_reg = 4'd2; wr_data = 16'h1234;
    mem_read = 1'b1; mem_addr = 16'h0020; mem_rdata = 16'hBEEF;
    gold_we = 1'b1; gold_waddr = 10'd2; gold_wdata = mk(2'd0, 4'd5, 16'h0000, 16'h0000);
    cyc(); idle_in(); gold_we = 1'b0;
    n_checks++;
    if ({done, ptr} !== {1'b0, 11'd2}) $display("FAIL dual_ptr got done=%b ptr=%0d want done=0 ptr=2", done, ptr);
    else n_pass++;
    halt = 1'b1;
    e = '{pass:1'b1, code:3'd0, idx:11'd0, ptr:11'd3, inst:32'd2, cyc:32'd2, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL dual_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({done, pass, fail, fail_code, ptr, inst_count, cycle_count} !== {1'b1, e.pass, ~e.pass, e.code, e.ptr, e.inst, e.cyc})
      $display("FAIL dual_result got pass=%b code=%0d ptr=%0d inst=%0d cyc=%0d want pass=1 code=0 ptr=%0d inst=%0d cyc=%0d",
               pass, fail_code, ptr, inst_count, cycle_count, e.ptr, e.inst, e.cyc);
    else n_pass++;
  endtask

  task automatic test_early_halt();
    load(10'd0, mk(2'd0, 4'd3, 16'h0000, 16'h0001));
    load(10'd1, mk(2'd3, 4'd0, 16'h0000, 16'h0000));
    load(10'd2, mk(2'd0, 4'd4, 16'h0000, 16'h0002));
    do_start(11'd3);
    reg_write = 1'b1; wr_reg = 4'd3; wr_data = 16'h0001;
    cyc(); idle_in();
    halt = 1'b1;
    e = '{pass:1'b0, code:3'd3, idx:11'd2, ptr:11'd2, inst:32'd2, cyc:32'd2, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL early_halt_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({fail, fail_code, fail_idx, ptr, inst_count} !== {1'b1, e.code, e.idx, e.ptr, e.inst})
      $display("FAIL early_halt got fail=%b code=%0d idx=%0d ptr=%0d inst=%0d want 1/%0d/%0d/%0d/%0d",
               fail, fail_code, fail_idx, ptr, inst_count, e.code, e.idx, e.ptr, e.inst);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_start(11'd1);
    reg_write = 1'b1; wr_reg = 4'd3; wr_data = 16'h0001;
    cyc();
    wr_reg = 4'd4; wr_data = 16'h0002;
    e = '{pass:1'b0, code:3'd2, idx:11'd1, ptr:11'd1, inst:32'd2, cyc:32'd2,
          exp_e:38'd0, act_e:mk(2'd0, 4'd4, 16'h0000, 16'h0002)};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL overrun_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({fail, fail_code, fail_idx, ptr, act_entry} !== {1'b1, e.code, e.idx, e.ptr, e.act_e})
      $display("FAIL overrun got code=%0d idx=%0d ptr=%0d act=%h want %0d/%0d/%0d/%h",
               fail_code, fail_idx, ptr, act_entry, e.code, e.idx, e.ptr, e.act_e);
    else n_pass++;
    do_start(11'd0);
    halt = 1'b1;
    e = '{pass:1'b0, code:3'd2, idx:11'd0, ptr:11'd0, inst:32'd1, cyc:32'd1, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL overrun_zero_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({fail, fail_code, fail_idx, ptr, cycle_count} !== {1'b1, e.code, e.idx, e.ptr, e.cyc})
      $display("FAIL overrun_zero got code=%0d idx=%0d ptr=%0d cyc=%0d want %0d/%0d/%0d/%0d",
               fail_code, fail_idx, ptr, cycle_count, e.code, e.idx, e.ptr, e.cyc);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_start(11'd3);
    e = '{pass:1'b0, code:3'd4, idx:11'd0, ptr:11'd0, inst:32'd0, cyc:32'd20, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL timeout_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({fail, fail_code, cycle_count, inst_count, ptr} !== {1'b1, e.code, e.cyc, e.inst, e.ptr})
      $display("FAIL timeout got code=%0d cyc=%0d inst=%0d ptr=%0d want %0d/%0d/%0d/%0d",
               fail_code, cycle_count, inst_count, ptr, e.code, e.cyc, e.inst, e.ptr);
    else n_pass++;
  endtask

  task automatic test_protocol();
    do_start(11'd3);
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 16'h0040;
    mem_wdata = 16'h1111; mem_rdata = 16'h2222;
    e = '{pass:1'b0, code:3'd5, idx:11'd0, ptr:11'd0, inst:32'd1, cyc:32'd1, exp_e:38'd0, act_e:38'd0};
    sb.push_back(e);
    cyc(); idle_in();
    wait_done(ok);
    n_checks++;
    if (!ok) $display("FAIL protocol_done got done=0 want 1 within budget");
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if ({fail, fail_code, fail_idx, act_entry, inst_count, cycle_count} !== {1'b1, e.code, e.idx, e.act_e, e.inst, e.cyc})
      $display("FAIL protocol got code=%0d idx=%0d act=%h inst=%0d cyc=%0d want %0d/%0d/%h/%0d/%0d",
               fail_code, fail_idx, act_entry, inst_count, cycle_count, e.code, e.idx, e.act_e, e.inst, e.cyc);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    load(10'd0, mk(2'd0, 4'd1, 16'h0000, 16'h0005));
    load(10'd1, mk(2'd2, 4'd0, 16'h0010, 16'h0005));
    load(10'd2, mk(2'd3, 4'd0, 16'h0000, 16'h0000));
    do_start(11'd3);
    reg_write = 1'b1; wr_reg = 4'd1; wr_data = 16'h0005;
    cyc(); idle_in();
    n_checks++;
    if (ptr !== 11'd1) $display("FAIL midrun_ptr got %0d want 1", ptr);
    else n_pass++;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n_checks++;
    if ({done, pass, fail, fail_code, fail_idx, exp_entry, act_entry, ptr, inst_count, cycle_count} !== 166'd0)
      $display("FAIL midrun_reset got done=%b code=%0d ptr=%0d inst=%0d cyc=%0d want all 0",
               done, fail_code, ptr, inst_count, cycle_count);
    else n_pass++;
    cyc();
    n_checks++;
    if ({done, ptr, cycle_count} !== 44'd0) $display("FAIL midrun_idle got done=%b ptr=%0d cyc=%0d want 0", done, ptr, cycle_count);
    else n_pass++;
    test_pass_basic(1'b0);
  endtask

  initial begin
    test_reset();
    test_pass_basic(1'b1);
    test_mismatch();
    test_dual_issue();
    test_early_halt();
    test_overrun();
    test_timeout();
    test_protocol();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
